two_bit_mult_sequencer: RTL and testbench
=========================================

TWO_BIT_MULT_SEQUENCER -- requirements
Module: two_bit_mult_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, giving the multiplier operand width; legal range 2..16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_vld  input  1  an operand pair is offered.
REQ-005 SHALL have port in_rdy  output  1  the sequencer accepts an operand pair.
REQ-006 SHALL have port in_a  input  16  multiplicand.
REQ-007 SHALL have port in_b  input  N  multiplier; any bit pattern.
REQ-008 SHALL have port mul_a  output  16  multiplicand to the downstream two-bit multiplier.
REQ-009 SHALL have port mul_b  output  N  partial multiplier; at most two bits set.
REQ-010 SHALL have port mul_vld  output  1  mul_a/mul_b are valid.
REQ-011 SHALL have port mul_c  input  32  product returned by the two-bit multiplier.
REQ-012 SHALL have port mul_result_vld  input  1  mul_c is valid this cycle.
REQ-013 SHALL have port out_vld  output  1  final product is available.
REQ-014 SHALL have port out_rdy  input  1  consumer takes the product.
REQ-015 SHALL have port out_p  output  32  final product in_a*in_b.
REQ-016 SHALL have port out_passes  output  $clog2(N)+1  number of multiplier passes used.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL drive in_rdy=1 only in IDLE.
REQ-019 SHALL, on accept (IDLE, in_vld=1), register in_a into a_reg and in_b into rem, clear acc and the pass count, and go to RUN; if in_b==0, it SHALL go straight to DONE instead.
REQ-020 SHALL, in RUN, drive mul_vld=1, mul_a=a_reg, and mul_b equal to the lowest one or two set bits of rem, combinationally from rem.
REQ-021 SHALL, in RUN on a cycle with mul_result_vld=1, add mul_c to acc modulo 2^32, clear the issued bits from rem, and increment the pass count.
REQ-022 SHALL, in RUN with mul_result_vld=0, hold rem, acc and the pass count unchanged.
REQ-023 SHALL go to DONE on the cycle where the update of REQ-021 leaves rem==0.
REQ-024 SHALL drive mul_vld=0, mul_a=0 and mul_b=0 outside RUN.
REQ-025 SHALL, in DONE, drive out_vld=1, out_p=acc and out_passes=the pass count, all held stable until out_rdy=1.
REQ-026 SHALL return to IDLE on the cycle DONE sees out_rdy=1; a new operand is accepted no earlier than the following cycle.
REQ-027 SHALL use ceil(popcount(in_b)/2) RUN cycles when mul_result_vld is constant 1; latency from accept to out_vld is that count plus 1 cycle.
REQ-028 SHALL ignore in_vld outside IDLE and mul_result_vld outside RUN.

Reset
REQ-029 SHALL, while rst=1, force state IDLE and clear a_reg, rem, acc and the pass count, independent of clk.
REQ-030 SHALL, from reset, drive in_rdy=1 and out_vld=0, with out_p, out_passes, mul_vld, mul_a and mul_b all 0.
REQ-031 SHALL, when reset is asserted mid-RUN or in DONE, discard the operation with no output produced.

Verification
REQ-032 SHALL cover: in_a=0x0003, in_b=0x00 -> no mul_vld pulse; out_vld 1 cycle after accept; out_p=0, out_passes=0.
REQ-033 SHALL cover: in_a=0x1234, in_b=0x05, mul_result_vld=1 -> one RUN cycle with mul_b=0x05; out_p=0x00005B04, out_passes=1.
REQ-034 SHALL cover: in_a=0xFFFF, in_b=0xFF -> mul_b sequence 0x03, 0x0C, 0x30, 0xC0; out_p=0x00FEFF01, out_passes=4.
REQ-035 SHALL cover: in_b=0x81, mul_result_vld held 0 for 3 cycles then 1 -> mul_b=0x81 is held for 4 cycles; out_p=in_a*0x81.
REQ-036 SHALL cover: out_rdy=0 for 5 cycles in DONE -> out_p stable and in_rdy=0 throughout; in_rdy=1 the cycle after out_rdy=1.
REQ-037 SHALL cover: rst pulsed during the second RUN cycle of in_b=0xFF -> all outputs 0 and in_rdy=1 immediately; the next operation is correct.

Source files
------------

// File: rtl/two_bit_mult_sequencer.sv
// rtl/two_bit_mult_sequencer.sv - splits a multiply into passes of an external two-bit multiplier
// The multiplier operand is consumed two set bits at a time, lowest first. Each
// pass hands the multiplicand plus a partial multiplier to an external unit.
// That unit returns the exact partial product, which is then accumulated.
// Zero bits of in_b cost nothing, so the pass count is ceil(popcount(in_b)/2).
module two_bit_mult_sequencer #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [15:0]          in_a,
  input  logic [N-1:0]         in_b,
  output logic [15:0]          mul_a,
  output logic [N-1:0]         mul_b,
  output logic                 mul_vld,
  input  logic [31:0]          mul_c,
  input  logic                 mul_result_vld,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [31:0]          out_p,
  output logic [$clog2(N):0]   out_passes
);

  localparam int PW = $clog2(N) + 1;
  localparam logic [N-1:0]  REM_ONE  = 1;
  localparam logic [PW-1:0] PASS_ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;

  logic [15:0]    a_reg;
  logic [N-1:0]   rem;
  logic [31:0]    acc;
  logic [PW-1:0]  passes;

  // Partial multiplier selection, derived purely from rem.
  logic [N-1:0]   low_bit;
  logic [N-1:0]   rest;
  logic [N-1:0]   next_bit;
  logic [N-1:0]   issue;
  logic [N-1:0]   rem_after;

  // Isolate the lowest two set bits of rem (x & -x picks the lowest one).
  always_comb begin
    low_bit   = rem & (~rem + REM_ONE);
    rest      = rem & ~low_bit;
    next_bit  = rest & (~rest + REM_ONE);
    issue     = low_bit | next_bit;
    rem_after = rem & ~issue;
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: zero multiplier skips RUN; RUN ends when the last bits retire.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_vld) begin
          state_nxt = (in_b == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (mul_result_vld && (rem_after == '0)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and accumulation; RUN only advances on a returned product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      rem    <= '0;
      acc    <= '0;
      passes <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld) begin
            a_reg  <= in_a;
            rem    <= in_b;
            acc    <= '0;
            passes <= '0;
          end
        end
        RUN: begin
          if (mul_result_vld) begin
            acc    <= acc + mul_c;
            rem    <= rem_after;
            passes <= passes + PASS_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode; everything not owned by the current state reads as zero.
  always_comb begin
    in_rdy     = 1'b0;
    mul_vld    = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    out_vld    = 1'b0;
    out_p      = '0;
    out_passes = '0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
      end
      RUN: begin
        mul_vld = 1'b1;
        mul_a   = a_reg;
        mul_b   = issue;
      end
      DONE: begin
        out_vld    = 1'b1;
        out_p      = acc;
        out_passes = passes;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_two_bit_mult_sequencer.sv
// tb/tb_two_bit_mult_sequencer.sv - self-checking bench for two_bit_mult_sequencer
module tb_two_bit_mult_sequencer;

  localparam int N  = 8;
  localparam int PW = $clog2(N) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_vld;
  logic           in_rdy;
  logic [15:0]    in_a;
  logic [N-1:0]   in_b;
  logic [15:0]    mul_a;
  logic [N-1:0]   mul_b;
  logic           mul_vld;
  logic [31:0]    mul_c;
  logic           mul_result_vld;
  logic           out_vld;
  logic           out_rdy;
  logic [31:0]    out_p;
  logic [PW-1:0]  out_passes;

  logic           res_en;

  int tests = 0;
  int fails = 0;

  logic [31:0]    exp_p_q[$];
  int             exp_n_q[$];
  logic [N-1:0]   mb_q[$];
  logic [15:0]    ma_q[$];

  always #5 clk = ~clk;

  two_bit_mult_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_vld(mul_vld),
    .mul_c(mul_c), .mul_result_vld(mul_result_vld),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_p(out_p), .out_passes(out_passes)
  );

  // Downstream multiplier model: exact product, answers whenever enabled.
  assign mul_c          = 32'(mul_a) * 32'(mul_b);
  assign mul_result_vld = mul_vld & res_en;

  function automatic int ones(input logic [N-1:0] b);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(b[i]);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair and record what the product must be.
  task automatic send(input logic [15:0] a, input logic [N-1:0] b);
    int cnt = 0;
    in_a   = a;
    in_b   = b;
    in_vld = 1'b1;
    while (!in_rdy && cnt < 100) begin
      tick();
      cnt++;
    end
    exp_p_q.push_back(32'(a) * 32'(b));
    exp_n_q.push_back((ones(b) + 1) / 2);
    tick();
    in_vld = 1'b0;
    in_a   = '0;
    in_b   = '0;
  endtask

  // Wait (bounded) for out_vld, logging every RUN cycle's mul_a/mul_b.
  task automatic wait_out(output bit ok);
    int i = 0;
    ok = 1'b0;
    mb_q.delete();
    ma_q.delete();
    while (!ok && i < 200) begin
      if (out_vld) begin
        ok = 1'b1;
      end else begin
        if (mul_vld) begin
          mb_q.push_back(mul_b);
          ma_q.push_back(mul_a);
        end
        tick();
        i++;
      end
    end
  endtask

  task automatic consume();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_rdy got %b exp 1", in_rdy); end
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL reset_out_vld got %b exp 0", out_vld); end
    tests++; if (out_p !== 32'h0) begin fails++; $display("FAIL reset_out_p got %h exp 0", out_p); end
    tests++; if (out_passes !== '0) begin fails++; $display("FAIL reset_out_passes got %0d exp 0", out_passes); end
    tests++; if ({mul_vld, mul_a, mul_b} !== '0) begin fails++; $display("FAIL reset_mul got vld %b a %h b %h exp 0", mul_vld, mul_a, mul_b); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_multiplier();
    bit ok;
    logic [31:0] ep;
    int en;
    send(16'h0003, 8'h00);
    tests++; if (out_vld !== 1'b1) begin fails++; $display("FAIL zero_latency out_vld got %b exp 1", out_vld); end
    wait_out(ok);
    ep = exp_p_q.pop_front();
    en = exp_n_q.pop_front();
    tests++; if (!ok) begin fails++; $display("FAIL zero_timeout got no out_vld exp out_vld"); end
    tests++; if (mb_q.size() != 0) begin fails++; $display("FAIL zero_mul_pulses got %0d exp 0", mb_q.size()); end
    tests++; if (out_p !== ep) begin fails++; $display("FAIL zero_out_p got %h exp %h", out_p, ep); end
    tests++; if (int'(out_passes) != en) begin fails++; $display("FAIL zero_passes got %0d exp %0d", out_passes, en); end
    consume();
  endtask

  task automatic test_single_pass();
    bit ok;
    logic [31:0] ep;
    int en;
    send(16'h1234, 8'h05);
    wait_out(ok);
    ep = exp_p_q.pop_front();
    en = exp_n_q.pop_front();
    tests++; if (!ok) begin fails++; $display("FAIL single_timeout got no out_vld exp out_vld"); end
    tests++; if (mb_q.size() != 1) begin fails++; $display("FAIL single_run_cycles got %0d exp 1", mb_q.size()); end
    else begin
      tests++; if (mb_q[0] !== 8'h05) begin fails++; $display("FAIL single_mul_b got %h exp 05", mb_q[0]); end
      tests++; if (ma_q[0] !== 16'h1234) begin fails++; $display("FAIL single_mul_a got %h exp 1234", ma_q[0]); end
    end
    tests++; if (out_p !== 32'h00005B04) begin fails++; $display("FAIL single_out_p got %h exp 00005b04", out_p); end
    tests++; if (out_p !== ep) begin fails++; $display("FAIL single_scoreboard got %h exp %h", out_p, ep); end
    tests++; if (int'(out_passes) != en) begin fails++; $display("FAIL single_passes got %0d exp %0d", out_passes, en); end
    consume();
  endtask

  task automatic test_full_byte();
    bit ok;
    logic [31:0] ep;
    int en;
    logic [N-1:0] seq [4];
    seq[0] = 8'h03; seq[1] = 8'h0C; seq[2] = 8'h30; seq[3] = 8'hC0;
    send(16'hFFFF, 8'hFF);
    wait_out(ok);
    ep = exp_p_q.pop_front();
    en = exp_n_q.pop_front();
    tests++; if (!ok) begin fails++; $display("FAIL full_timeout got no out_vld exp out_vld"); end
    tests++; if (mb_q.size() != 4) begin fails++; $display("FAIL full_run_cycles got %0d exp 4", mb_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        tests++; if (mb_q[i] !== seq[i]) begin fails++; $display("FAIL full_mul_b[%0d] got %h exp %h", i, mb_q[i], seq[i]); end
      end
    end
    tests++; if (out_p !== 32'h00FEFF01) begin fails++; $display("FAIL full_out_p got %h exp 00feff01", out_p); end
    tests++; if (out_p !== ep) begin fails++; $display("FAIL full_scoreboard got %h exp %h", out_p, ep); end
    tests++; if (int'(out_passes) != en) begin fails++; $display("FAIL full_passes got %0d exp %0d", out_passes, en); end
    consume();
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] ep;
    int en;
    res_en = 1'b0;
    send(16'h00A5, 8'h81);
    for (int i = 0; i < 3; i++) begin
      tests++; if (!(mul_vld === 1'b1 && mul_b === 8'h81)) begin fails++; $display("FAIL stall_hold[%0d] got vld %b b %h exp vld 1 b 81", i, mul_vld, mul_b); end
      tick();
    end
    res_en = 1'b1;
    wait_out(ok);
    ep = exp_p_q.pop_front();
    en = exp_n_q.pop_front();
    tests++; if (!ok) begin fails++; $display("FAIL stall_timeout got no out_vld exp out_vld"); end
    tests++; if (mb_q.size() != 1 || mb_q[0] !== 8'h81) begin fails++; $display("FAIL stall_final_pass got %0d cycles exp 1 cycle of 81", mb_q.size()); end
    tests++; if (out_p !== ep) begin fails++; $display("FAIL stall_out_p got %h exp %h", out_p, ep); end
    tests++; if (int'(out_passes) != en) begin fails++; $display("FAIL stall_passes got %0d exp %0d", out_passes, en); end
    consume();
  endtask

  task automatic test_out_hold();
    bit ok;
    logic [31:0] ep;
    int en;
    send(16'h0BCD, 8'h3C);
    wait_out(ok);
    ep = exp_p_q.pop_front();
    en = exp_n_q.pop_front();
    tests++; if (!ok) begin fails++; $display("FAIL hold_timeout got no out_vld exp out_vld"); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_vld !== 1'b1 || out_p !== ep || in_rdy !== 1'b0 || int'(out_passes) != en) begin
        fails++;
        $display("FAIL hold[%0d] got vld %b p %h rdy %b n %0d exp vld 1 p %h rdy 0 n %0d", i, out_vld, out_p, in_rdy, out_passes, ep, en);
      end
      tick();
    end
    consume();
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL hold_release in_rdy got %b exp 1", in_rdy); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    logic [31:0] ep;
    int en;
    send(16'hFFFF, 8'hFF);
    tick();
    tests++; if (mul_vld !== 1'b1 || mul_b !== 8'h0C) begin fails++; $display("FAIL midrun_second_pass got vld %b b %h exp vld 1 b 0c", mul_vld, mul_b); end
    rst = 1'b1;
    #1;
    void'(exp_p_q.pop_back());
    void'(exp_n_q.pop_back());
    tests++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0 || out_p !== '0 || out_passes !== '0 || mul_vld !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin
      fails++;
      $display("FAIL midrun_reset got rdy %b ov %b p %h n %0d mv %b a %h b %h exp rdy 1 rest 0", in_rdy, out_vld, out_p, out_passes, mul_vld, mul_a, mul_b);
    end
    #2;
    rst = 1'b0;
    tick();
    tests++; if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin fails++; $display("FAIL midrun_after got ov %b rdy %b exp ov 0 rdy 1", out_vld, in_rdy); end
    send(16'h0007, 8'h5A);
    wait_out(ok);
    ep = exp_p_q.pop_front();
    en = exp_n_q.pop_front();
    tests++; if (!ok) begin fails++; $display("FAIL midrun_next_timeout got no out_vld exp out_vld"); end
    tests++; if (out_p !== ep) begin fails++; $display("FAIL midrun_next_out_p got %h exp %h", out_p, ep); end
    tests++; if (int'(out_passes) != en) begin fails++; $display("FAIL midrun_next_passes got %0d exp %0d", out_passes, en); end
    consume();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] ep;
    int en;
    logic [15:0] a;
    logic [N-1:0] b;
    for (int k = 0; k < 12; k++) begin
      a = 16'($urandom);
      b = N'($urandom);
      if (k == 0) b = 8'h80;
      if (k == 1) b = 8'h01;
      if (k == 2) a = 16'hFFFF;
      send(a, b);
      wait_out(ok);
      ep = exp_p_q.pop_front();
      en = exp_n_q.pop_front();
      tests++;
      if (!ok || out_p !== ep || int'(out_passes) != en || mb_q.size() != en) begin
        fails++;
        $display("FAIL b2b[%0d] a %h b %h got p %h n %0d runs %0d exp p %h n %0d", k, a, b, out_p, out_passes, mb_q.size(), ep, en);
      end
      consume();
    end
  endtask

  initial begin
    rst    = 1'b1;
    in_vld = 1'b0;
    in_a   = '0;
    in_b   = '0;
    out_rdy = 1'b0;
    res_en = 1'b1;
    test_reset();
    test_zero_multiplier();
    test_single_pass();
    test_full_byte();
    test_stall();
    test_out_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
